serializer_16to1: RTL and testbench
===================================

# serializer_16to1

Parallel-to-serial stage placed directly upstream of the 16-to-1 decoded multiplexer. It accepts a 16-bit word through the dav_/rfd handshake and holds it in an internal buffer. It then steps a 4-bit select counter, so the buffer and the select together drive the decoded mux and one bit is emitted per clock. It drives `b3_b0` on the mux's command input, and the mux instance inside this block produces `z0`.

## Interface
- `MSB_FIRST`, default 0: 0 emits bit 0 first, 1 emits bit 15 first.

- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset_`  in  1  synchronous, active-low reset, sampled on the `clock` rising edge.
- `dav_`  in  1  data available, active low, driven by the producer.
- `x15_x0`  in  16  parallel word; sampled only on the load edge.
- `rfd`  out  1  ready for data; registered.
- `b3_b0`  out  4  current mux select; `MSB_FIRST ? 15-cnt : cnt`.
- `z0`  out  1  serial bit; output of the decoded mux on `buf[b3_b0]`.
- `valid`  out  1  high while `z0` carries a word bit.
- `last`  out  1  high during the final bit of a word.

## Operation
- Internal registers:
  - `buf[15:0]`
  - `cnt[3:0]`
  - `state`, one of `S_WAIT`, `S_SHIFT`, `S_ACK`
  - `rfd`
- `z0`, `valid`, `last` and `b3_b0` are combinational from the registers; there is no extra output flop.
  - `valid` = `state==S_SHIFT`.
  - `last` = `valid & cnt==15`.
- Reset (`reset_`=0 at an edge):
  - `state`=`S_WAIT`, `rfd`=1, `cnt`=0, `buf`=0.
  - Hence `valid`=0, `last`=0, `z0`=0, and `b3_b0`=0 (or 15 if `MSB_FIRST`).
  - Reset overrides everything, including mid-word; a partially sent word is discarded and no `last` is produced.
- `S_WAIT`:
  - `dav_`=0 at an edge: `buf`<=`x15_x0`, `cnt`<=0, `rfd`<=0, go to `S_SHIFT`.
  - Otherwise hold.
- `S_SHIFT`:
  - Each edge `cnt`<=`cnt`+1.
  - At the edge where `cnt`==15: `cnt`<=0 (4-bit wrap) and go to `S_ACK`.
  - `dav_` and `x15_x0` are ignored; `buf` is constant.
- `S_ACK`:
  - `dav_`=1 at an edge: `rfd`<=1, go to `S_WAIT`.
  - Otherwise hold with `rfd`=0.
  - A producer that keeps `dav_` low stalls the block here indefinitely.
- No new word is accepted until the producer has released `dav_` and `rfd` has returned to 1. A `dav_` that is still low from the previous word never causes a reload.
- `x15_x0` changing outside the load edge has no effect.

## Timing
- Load edge E0: `S_WAIT` with `dav_`=0.
- Cycle after E0: `valid`=1, `z0`=first bit.
- Edges E1..E15 each advance one bit.
  - The cycle after E15 carries the final bit with `last`=1.
- Edge E16 enters `S_ACK`: `valid`=0.
- If `dav_` is already 1 when sampled at E17 in `S_ACK`:
  - `rfd`=1 from E17.
  - The earliest next load is at E18.
- Word period is at least 18 cycles, with exactly 16 `valid` cycles per word.
- Latency from load edge to first bit is 1 cycle.
- `rfd` falls at E0, so it is low in the cycle after the load.

## Test plan
- Reset then idle:
  - Stimulus: hold `reset_`=0 for 2 edges, then release with `dav_`=1.
  - Required: `rfd`=1, `valid`=0, `z0`=0, `last`=0.
  - Required: state is held in `S_WAIT` for 10 cycles.
- Load LSB-first:
  - Stimulus: `MSB_FIRST`=0, `x15_x0`=16'hA5C3, `dav_` pulsed low for 1 cycle.
  - Required: `z0` sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - Required: `valid` is high for exactly 16 cycles and `last` only on the 16th.
  - Required: `rfd` returns to 1 two edges after the last bit.
- Load MSB-first:
  - Stimulus: `MSB_FIRST`=1, word 16'h8001.
  - Required: `z0`=1 in the first cycle, 0 for the next 14 cycles, 1 in the 16th cycle.
  - Required: `b3_b0` counts 15 down to 0.
- Held `dav_`:
  - Stimulus: keep `dav_`=0 for 30 cycles after the load.
  - Required: exactly one word is sent, `rfd` stays 0, state holds in `S_ACK` while `dav_`=0.
  - Required: after `dav_`=1, `rfd`=1 the next cycle and no reload occurs.
- Input change mid-word:
  - Stimulus: change `x15_x0` to 16'hFFFF during `S_SHIFT` after loading 16'h0000.
  - Required: `z0` stays 0 for all 16 bits.
- Reset mid-word:
  - Stimulus: assert `reset_`=0 at the 6th bit.
  - Required: from the next cycle `valid`=0, `last` never rises, `rfd`=1, `cnt`=0.
  - Required: a subsequent load streams normally.

Source files
------------

// File: rtl/serializer_16to1.sv
// 16-bit parallel-to-serial stage with dav_/rfd handshake. A 4-bit select
// counter walks a held buffer through a decoded 16-to-1 mux, one bit per clock.
module serializer_16to1 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        dav_,
  input  logic [15:0] x15_x0,
  output logic        rfd,
  output logic [3:0]  b3_b0,
  output logic        z0,
  output logic        valid,
  output logic        last
);

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  logic [15:0] buf_r;
  logic [3:0]  cnt_r;
  logic [1:0]  state_r;
  logic        rfd_r;
  logic [3:0]  sel_s;
  logic [15:0] dec_s;

  // One-hot decode of the mux command input.
  function automatic logic [15:0] decode_sel(input logic [3:0] sel);
    logic [15:0] onehot;
    onehot = 16'd0;
    for (int i = 0; i < 16; i++) begin
      if (sel == i[3:0]) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
    return onehot;
  endfunction

  // Handshake FSM, buffer load and select counter.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_r <= S_WAIT;
      rfd_r   <= 1'b1;
      cnt_r   <= 4'd0;
      buf_r   <= 16'd0;
    end else begin
      case (state_r)
        S_WAIT: begin
          if (!dav_) begin
            buf_r   <= x15_x0;
            cnt_r   <= 4'd0;
            rfd_r   <= 1'b0;
            state_r <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // 4-bit wrap brings cnt back to 0 on the final bit.
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == 4'd15) begin
            state_r <= S_ACK;
          end
        end
        S_ACK: begin
          if (dav_) begin
            rfd_r   <= 1'b1;
            state_r <= S_WAIT;
          end
        end
        default: begin
          state_r <= S_WAIT;
          rfd_r   <= 1'b1;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // Bit order only changes how the count maps onto the mux select.
  always_comb begin
    sel_s = 4'd0;
    if (MSB_FIRST) begin
      sel_s = 4'd15 - cnt_r;
    end else begin
      sel_s = cnt_r;
    end
  end

  // Decoded mux: AND each buffer bit with its select line, then OR-reduce.
  always_comb begin
    dec_s = decode_sel(sel_s);
  end

  assign z0    = |(dec_s & buf_r);
  assign b3_b0 = sel_s;
  assign rfd   = rfd_r;
  assign valid = (state_r == S_SHIFT);
  assign last  = valid & (cnt_r == 4'd15);

endmodule

// File: tb/tb_serializer_16to1.sv
// Directed bench for serializer_16to1: LSB-first and MSB-first instances share
// one stimulus stream; inputs change and outputs are sampled on falling edges.
module tb_serializer_16to1;

  logic        clock = 1'b0;
  logic        reset_;
  logic        dav_;
  logic [15:0] x15_x0;

  logic        rfd0, z00, valid0, last0;
  logic [3:0]  sel0;
  logic        rfd1, z01, valid1, last1;
  logic [3:0]  sel1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  serializer_16to1 #(.MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset_(reset_), .dav_(dav_), .x15_x0(x15_x0),
    .rfd(rfd0), .b3_b0(sel0), .z0(z00), .valid(valid0), .last(last0)
  );

  serializer_16to1 #(.MSB_FIRST(1'b1)) dut_msb (
    .clock(clock), .reset_(reset_), .dav_(dav_), .x15_x0(x15_x0),
    .rfd(rfd1), .b3_b0(sel1), .z0(z01), .valid(valid1), .last(last1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present a word with dav_ low for one edge; returns in the first bit cycle.
  task automatic load(input logic [15:0] w, input bit hold_dav);
    @(negedge clock);
    x15_x0 = w;
    dav_   = 1'b0;
    @(negedge clock);
    if (!hold_dav) dav_ = 1'b1;
  endtask

  // Check all 16 bit cycles plus the two handshake cycles that follow.
  task automatic stream(input logic [15:0] w, input bit released);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clock);
      if (i == 1) x15_x0 = ~w;
      check("valid_lsb", 16'(valid0), 16'd1);
      check("valid_msb", 16'(valid1), 16'd1);
      check("z0_lsb", 16'(z00), 16'(w[i]));
      check("z0_msb", 16'(z01), 16'(w[15-i]));
      check("last_lsb", 16'(last0), 16'(i == 15));
      check("sel_lsb", 16'(sel0), 16'(i));
      check("sel_msb", 16'(sel1), 16'(15 - i));
      check("rfd_busy", 16'(rfd0), 16'd0);
    end
    @(negedge clock);
    check("valid_ack", 16'(valid0), 16'd0);
    check("last_ack", 16'(last0), 16'd0);
    check("rfd_ack", 16'(rfd0), 16'd0);
    @(negedge clock);
    check("rfd_back", 16'(rfd0), 16'(released));
    check("valid_idle", 16'(valid0), 16'd0);
  endtask

  initial begin
    reset_ = 1'b0;
    dav_   = 1'b1;
    x15_x0 = 16'h0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_rfd", 16'(rfd0), 16'd1);
    check("rst_valid", 16'(valid0), 16'd0);
    check("rst_z0", 16'(z00), 16'd0);
    check("rst_last", 16'(last0), 16'd0);
    check("rst_sel_lsb", 16'(sel0), 16'd0);
    check("rst_sel_msb", 16'(sel1), 16'd15);
    reset_ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_rfd", 16'(rfd0), 16'd1);
      check("idle_valid", 16'(valid0), 16'd0);
    end

    // A5C3 LSB-first: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
    load(16'hA5C3, 1'b0);
    stream(16'hA5C3, 1'b1);

    // 8001 MSB-first: 1, fourteen 0s, 1
    load(16'h8001, 1'b0);
    stream(16'h8001, 1'b1);

    // dav_ held low for 30 cycles after the load.
    load(16'h3C96, 1'b1);
    stream(16'h3C96, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check("held_rfd", 16'(rfd0), 16'd0);
      check("held_valid", 16'(valid0), 16'd0);
    end
    dav_ = 1'b1;
    @(negedge clock);
    check("held_release_rfd", 16'(rfd0), 16'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("no_reload", 16'(valid0), 16'd0);
    end

    // 0000 loaded; the stream drives FFFF onto x15_x0 mid-word.
    load(16'h0000, 1'b0);
    stream(16'h0000, 1'b1);

    // Reset during the 6th bit.
    load(16'hFFFF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clock);
      check("pre_rst_z0", 16'(z00), 16'd1);
      check("pre_rst_last", 16'(last0), 16'd0);
    end
    reset_ = 1'b0;
    @(negedge clock);
    reset_ = 1'b1;
    check("midrst_valid", 16'(valid0), 16'd0);
    check("midrst_last", 16'(last0), 16'd0);
    check("midrst_rfd", 16'(rfd0), 16'd1);
    check("midrst_cnt", 16'(sel0), 16'd0);
    check("midrst_z0", 16'(z00), 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("post_rst_valid", 16'(valid0), 16'd0);
      check("post_rst_last", 16'(last0), 16'd0);
    end
    load(16'h1234, 1'b0);
    stream(16'h1234, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
